// File: rtl/contador_cm_param_if.sv
// Echo-ranging bundle between the sensor front end and the cm counter.
// The master drives the synchronised echo; the slave returns the BCD distance and status.
interface contador_cm_param_if #(
    parameter int DIGITS = 3
) ();
    logic                  pulso;
    logic [4*DIGITS-1:0]   distancia;
    logic                  pronto;
    logic                  timeout;
    logic                  medindo;

    modport master (
        output pulso,
        input  distancia,
        input  pronto,
        input  timeout,
        input  medindo
    );

    modport slave (
        input  pulso,
        output distancia,
        output pronto,
        output timeout,
        output medindo
    );
endinterface

// File: rtl/contador_cm_param.sv
// Echo-pulse to BCD centimetre converter: tick divider, DIGITS-wide BCD counter, range timeout.
// Optional half-cm rounding is enabled by defining CONTADOR_CM_ROUND_EN.
module contador_cm_param #(
    parameter int TICKS_PER_CM = 2941,
    parameter int DIGITS       = 3,
    parameter int MAX_CM       = 400
) (
    input  logic               clock,
    input  logic               reset,
    contador_cm_param_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int TW = $clog2(TICKS_PER_CM);

    function automatic logic [BW-1:0] to_bcd(input int value);
        logic [BW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] x);
        logic [BW-1:0] r;
        logic          c;
        r = x;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (x[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = x[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = x[4*i +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [BW-1:0] MAX_BCD  = to_bcd(MAX_CM);
    localparam logic [TW-1:0] TICK_TOP = TW'(TICKS_PER_CM - 1);

    generate
        if (TICKS_PER_CM < 2 || MAX_CM < 1 || MAX_CM > (10 ** DIGITS) - 1) begin : g_bad_param
            $error("contador_cm_param: illegal TICKS_PER_CM/MAX_CM/DIGITS combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEDE = 2'd1,
        TOUT = 2'd2,
        FIM  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] cm_q, cm_d;
    logic [BW-1:0] dist_q, dist_d;
    logic          tout_q, tout_d;

    logic          pronto_s;
    logic          medindo_s;
    logic          wrap_s;
    logic          rnd_s;
    logic [BW-1:0] cm_inc_s;
    logic [BW-1:0] sum_s;
    logic [BW-1:0] result_s;

    assign wrap_s   = (tcnt_q == TICK_TOP);
    assign cm_inc_s = bcd_inc(cm_q);

`ifdef CONTADOR_CM_ROUND_EN
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_CM / 2);
    assign rnd_s = (tcnt_q >= TICK_HALF);
`else
    assign rnd_s = 1'b0;
`endif

    // Valid BCD orders like unsigned binary, so the clamp can compare directly.
    assign sum_s    = rnd_s ? cm_inc_s : cm_q;
    assign result_s = (sum_s > MAX_BCD) ? MAX_BCD : sum_s;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.pulso) state_d = MEDE;
                else           state_d = IDLE;
            end
            MEDE: begin
                if (!bus.pulso)                          state_d = FIM;
                else if (wrap_s && cm_inc_s == MAX_BCD)  state_d = TOUT;
                else                                     state_d = MEDE;
            end
            TOUT: begin
                if (!bus.pulso) state_d = FIM;
                else            state_d = TOUT;
            end
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        pronto_s  = 1'b0;
        medindo_s = 1'b0;
        case (state_q)
            IDLE: begin
                pronto_s  = 1'b0;
                medindo_s = 1'b0;
            end
            MEDE, TOUT: begin
                pronto_s  = 1'b0;
                medindo_s = 1'b1;
            end
            FIM: begin
                pronto_s  = 1'b1;
                medindo_s = 1'b0;
            end
            default: begin
                pronto_s  = 1'b0;
                medindo_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: tick divider, BCD counter, result latch, sticky timeout.
    always_comb begin
        tcnt_d = tcnt_q;
        cm_d   = cm_q;
        dist_d = dist_q;
        tout_d = tout_q;
        case (state_q)
            IDLE: begin
                // The sample that starts the measurement is already one tick of echo.
                if (bus.pulso) begin
                    tcnt_d = TW'(1);
                    cm_d   = '0;
                    tout_d = 1'b0;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            MEDE: begin
                if (bus.pulso) begin
                    if (wrap_s) begin
                        tcnt_d = '0;
                        cm_d   = cm_inc_s;
                        if (cm_inc_s == MAX_BCD) tout_d = 1'b1;
                        else                     tout_d = tout_q;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end else begin
                    dist_d = result_s;
                end
            end
            TOUT: begin
                if (!bus.pulso) dist_d = MAX_BCD;
                else            dist_d = dist_q;
            end
            FIM:     dist_d = dist_q;
            default: dist_d = dist_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
            cm_q   <= '0;
            dist_q <= '0;
            tout_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            cm_q   <= cm_d;
            dist_q <= dist_d;
            tout_q <= tout_d;
        end
    end

    assign bus.distancia = dist_q;
    assign bus.timeout   = tout_q;
    assign bus.pronto    = pronto_s;
    assign bus.medindo   = medindo_s;
endmodule
